// File: rtl/branch_target_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer_pkg
//  Description : Shared types, defaults and saturating-counter helpers for the
//                branch target buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_target_buffer_pkg;

    localparam int BTB_ENTRIES_DEF = 16;
    localparam int BTB_CNT_W_DEF   = 2;

    // Sized for the widest legal configuration (IDX_W >= 1, CNT_W <= 4)
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        logic [3:0]  ctr;
    } btb_entry_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input int w);
        logic [4:0] lim;
        lim = 5'((1 << w) - 1);
        if ({1'b0, v} >= lim) return v;
        return v + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v, input int w);
        if (w < 1 || v == 4'd0) return v;
        return v - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer_if
//  Description : Signal bundle for the branch target buffer, with block-side
//                and bench-side views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_buffer_if (
    input logic CLK
);
    logic        RST;
    logic        flush_all;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [31:0] hit_count;
    logic [31:0] mispredict_count;

    modport bp (
        input  CLK, RST, flush_all, lookup_en, lookup_pc,
        input  upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, recover_pc, hit_count, mispredict_count
    );

    modport tb (
        input  CLK,
        output RST, flush_all, lookup_en, lookup_pc,
        output upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, recover_pc, hit_count, mispredict_count
    );

endinterface
`default_nettype wire

// File: rtl/branch_target_buffer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : CNT_W-bit saturating up/down counter with load and a
//                port-supplied reset value; exposes the direction bit (MSB).
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import branch_target_buffer_pkg::*;
#(
    parameter int CNT_W = BTB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic [CNT_W-1:0] i_rst_val,
    output logic             o_msb
);

    logic [CNT_W-1:0] r_ctr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr <= i_rst_val;
        end else if (i_load) begin
            r_ctr <= i_load_val;
        end else if (i_inc) begin
            r_ctr <= CNT_W'(sat_inc(4'(r_ctr), CNT_W));
        end else if (i_dec) begin
            r_ctr <= CNT_W'(sat_dec(4'(r_ctr), CNT_W));
        end
    end

    assign o_msb = r_ctr[CNT_W-1];

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Direct-mapped BTB with saturating-counter direction
//                prediction, MEM-stage training and mispredict recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES_DEF,
    parameter int CNT_W   = BTB_CNT_W_DEF,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush_all,
    input  logic        lookup_en,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] recover_pc,
    output logic [31:0] hit_count,
    output logic [31:0] mispredict_count
);

    localparam int               c_TAG_W     = 30 - IDX_W;
    localparam logic [CNT_W-1:0] c_CTR_RST   = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_CTR_ALLOC = CNT_W'(1 << (CNT_W - 1));

    logic [ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [29:0]        r_target [ENTRIES];
    logic [31:0]        r_hit_count;
    logic [31:0]        r_mis_count;

    logic [ENTRIES-1:0] w_ctr_msb;
    logic [ENTRIES-1:0] w_inc;
    logic [ENTRIES-1:0] w_dec;
    logic [ENTRIES-1:0] w_load;
    logic [IDX_W-1:0]   w_lk_idx;
    logic [IDX_W-1:0]   w_up_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_lk_hit;
    logic               w_up_hit;
    logic               w_upd_act;
    logic               w_mispredict;

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[31:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[31:IDX_W+2];

    // Lookups read the arrays before this edge's write (read-before-write)
    assign w_lk_hit    = ~RST & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = w_lk_hit & w_ctr_msb[w_lk_idx];
    assign pred_target = pred_taken ? {r_target[w_lk_idx], 2'b00} : lookup_pc + 32'd4;

    assign w_up_hit  = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
    assign w_upd_act = upd_en & ~flush_all;

    assign w_mispredict = upd_en & ((upd_pred_taken != upd_taken) |
                                    (upd_taken & (upd_pred_target != upd_target)));
    assign mispredict   = w_mispredict;
    assign recover_pc   = upd_taken ? upd_target : upd_pc + 32'd4;

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            logic w_sel;
            assign w_sel     = w_upd_act & (w_up_idx == IDX_W'(i));
            assign w_load[i] = w_sel & upd_taken & ~w_up_hit;
            assign w_inc[i]  = w_sel & upd_taken & w_up_hit;
            assign w_dec[i]  = w_sel & ~upd_taken & w_up_hit;

            sat_counter #(
                .CNT_W (CNT_W)
            ) u_ctr (
                .clk        (CLK),
                .rst        (RST),
                .i_inc      (w_inc[i]),
                .i_dec      (w_dec[i]),
                .i_load     (w_load[i]),
                .i_load_val (c_CTR_ALLOC),
                .i_rst_val  (c_CTR_RST),
                .o_msb      (w_ctr_msb[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
        end else if (flush_all) begin
            r_valid <= '0;
        end else if (w_upd_act & upd_taken) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Taken updates rewrite tag and target whether allocating or reinforcing
    always_ff @(posedge CLK) begin
        if (~RST & w_upd_act & upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target[31:2];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_count <= '0;
            r_mis_count <= '0;
        end else begin
            if (lookup_en & w_lk_hit & (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_mispredict & (r_mis_count != 32'hFFFF_FFFF)) begin
                r_mis_count <= r_mis_count + 32'd1;
            end
        end
    end

    assign hit_count        = r_hit_count;
    assign mispredict_count = r_mis_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_buffer
//  Description : Directed vector bench for branch_target_buffer, with a
//                saturation sweep on two extra parameterisations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_target_buffer_if bif (.CLK(clk));

    logic        s_pred_taken, l_pred_taken;
    logic [31:0] s_pred_target, l_pred_target;
    logic        s_mis, l_mis;
    logic [31:0] s_rec, l_rec, s_hits, l_hits, s_misc, l_misc;

    branch_target_buffer #(.ENTRIES(16), .CNT_W(2)) u_dut (
        .CLK(bif.CLK), .RST(bif.RST), .flush_all(bif.flush_all),
        .lookup_en(bif.lookup_en), .lookup_pc(bif.lookup_pc),
        .pred_taken(bif.pred_taken), .pred_target(bif.pred_target),
        .upd_en(bif.upd_en), .upd_pc(bif.upd_pc), .upd_taken(bif.upd_taken),
        .upd_target(bif.upd_target), .upd_pred_taken(bif.upd_pred_taken),
        .upd_pred_target(bif.upd_pred_target), .mispredict(bif.mispredict),
        .recover_pc(bif.recover_pc), .hit_count(bif.hit_count),
        .mispredict_count(bif.mispredict_count)
    );

    branch_target_buffer #(.ENTRIES(2), .CNT_W(1)) u_small (
        .CLK(clk), .RST(bif.RST), .flush_all(bif.flush_all),
        .lookup_en(bif.lookup_en), .lookup_pc(bif.lookup_pc),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .upd_en(bif.upd_en), .upd_pc(bif.upd_pc), .upd_taken(bif.upd_taken),
        .upd_target(bif.upd_target), .upd_pred_taken(bif.upd_pred_taken),
        .upd_pred_target(bif.upd_pred_target), .mispredict(s_mis),
        .recover_pc(s_rec), .hit_count(s_hits), .mispredict_count(s_misc)
    );

    branch_target_buffer #(.ENTRIES(256), .CNT_W(4)) u_large (
        .CLK(clk), .RST(bif.RST), .flush_all(bif.flush_all),
        .lookup_en(bif.lookup_en), .lookup_pc(bif.lookup_pc),
        .pred_taken(l_pred_taken), .pred_target(l_pred_target),
        .upd_en(bif.upd_en), .upd_pc(bif.upd_pc), .upd_taken(bif.upd_taken),
        .upd_target(bif.upd_target), .upd_pred_taken(bif.upd_pred_taken),
        .upd_pred_target(bif.upd_pred_target), .mispredict(l_mis),
        .recover_pc(l_rec), .hit_count(l_hits), .mispredict_count(l_misc)
    );

    typedef struct {
        logic        rst, flush, lk_en;
        logic [31:0] lk_pc;
        logic        upd_en;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        upd_ptaken;
        logic [31:0] upd_ptarget;
        logic        e_ptaken;
        logic [31:0] e_ptarget;
        logic        e_mis;
        logic [31:0] e_rec, e_hits, e_misc;
    } vec_t;

    vec_t vecs [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic flush, input logic lk_en, input logic [31:0] lk_pc,
                       input logic upd_en, input logic [31:0] upd_pc, input logic upd_taken,
                       input logic [31:0] upd_target, input logic upd_ptaken, input logic [31:0] upd_ptarget,
                       input logic e_ptaken, input logic [31:0] e_ptarget, input logic e_mis,
                       input logic [31:0] e_rec, input logic [31:0] e_hits, input logic [31:0] e_misc);
        vec_t v;
        v.rst = rst; v.flush = flush; v.lk_en = lk_en; v.lk_pc = lk_pc;
        v.upd_en = upd_en; v.upd_pc = upd_pc; v.upd_taken = upd_taken; v.upd_target = upd_target;
        v.upd_ptaken = upd_ptaken; v.upd_ptarget = upd_ptarget;
        v.e_ptaken = e_ptaken; v.e_ptarget = e_ptarget; v.e_mis = e_mis; v.e_rec = e_rec;
        v.e_hits = e_hits; v.e_misc = e_misc;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bif.RST             = v.rst;
        bif.flush_all       = v.flush;
        bif.lookup_en       = v.lk_en;
        bif.lookup_pc       = v.lk_pc;
        bif.upd_en          = v.upd_en;
        bif.upd_pc          = v.upd_pc;
        bif.upd_taken       = v.upd_taken;
        bif.upd_target      = v.upd_target;
        bif.upd_pred_taken  = v.upd_ptaken;
        bif.upd_pred_target = v.upd_ptarget;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // One sweep cycle: lookup 0x40 while presenting an update on 0x40
    task automatic sweep_upd(input logic taken);
        @(negedge clk);
        bif.RST = 1'b0; bif.flush_all = 1'b0; bif.lookup_en = 1'b1; bif.lookup_pc = 32'h40;
        bif.upd_en = 1'b1; bif.upd_pc = 32'h40; bif.upd_taken = taken; bif.upd_target = 32'h100;
        bif.upd_pred_taken = 1'b0; bif.upd_pred_target = 32'h0;
    endtask

    task automatic sweep_chk(input int idx, input logic e_s, input logic e_l);
        @(negedge clk);
        bif.upd_en = 1'b0; bif.lookup_pc = 32'h40;
        #2;
        check("small.pred_taken", idx, 32'(s_pred_taken), 32'(e_s));
        check("small.pred_target", idx, s_pred_target, e_s ? 32'h100 : 32'h44);
        check("large.pred_taken", idx, 32'(l_pred_taken), 32'(e_l));
        check("large.pred_target", idx, l_pred_target, e_l ? 32'h100 : 32'h44);
    endtask

    initial begin
        bif.RST = 1'b1; bif.flush_all = 1'b0; bif.lookup_en = 1'b0; bif.lookup_pc = 32'h40;
        bif.upd_en = 1'b0; bif.upd_pc = 32'h0; bif.upd_taken = 1'b0; bif.upd_target = 32'h0;
        bif.upd_pred_taken = 1'b0; bif.upd_pred_target = 32'h0;

        //   rst fl en lk_pc         upd pc           tk target      ptk ptarget   ept etarget    mis rec         hits misc
        add(0, 0, 1, 32'h40,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h44,     0, 32'h0,       0,  0);
        add(0, 0, 1, 32'h40,        1, 32'h40,       1, 32'h100,    0, 32'h44,    0, 32'h44,     1, 32'h100,     0,  0);
        add(0, 0, 1, 32'h40,        0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h100,    0, 32'h0,       0,  1);
        add(0, 0, 1, 32'h40,        1, 32'h40,       0, 32'h300,    1, 32'h100,   1, 32'h100,    1, 32'h44,      1,  1);
        add(0, 0, 1, 32'h40,        1, 32'h40,       0, 32'h300,    0, 32'h44,    0, 32'h44,     0, 32'h0,       2,  2);
        add(0, 0, 1, 32'h40,        1, 32'h40,       0, 32'h300,    0, 32'h44,    0, 32'h44,     0, 32'h0,       3,  2);
        add(0, 0, 1, 32'h40,        1, 32'h40,       1, 32'h100,    0, 32'h44,    0, 32'h44,     1, 32'h100,     4,  2);
        add(0, 0, 1, 32'h40,        1, 32'h40,       1, 32'h100,    0, 32'h44,    0, 32'h44,     1, 32'h100,     5,  3);
        add(0, 0, 1, 32'h40,        1, 32'h40,       1, 32'h100,    1, 32'h100,   1, 32'h100,    0, 32'h0,       6,  4);
        add(0, 0, 1, 32'h40,        1, 32'h40,       1, 32'h100,    1, 32'h100,   1, 32'h100,    0, 32'h0,       7,  4);
        add(0, 0, 1, 32'h40,        0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h100,    0, 32'h0,       8,  4);
        add(0, 0, 1, 32'h40,        1, 32'h40,       0, 32'h300,    1, 32'h100,   1, 32'h100,    1, 32'h44,      9,  4);
        add(0, 0, 1, 32'h40,        0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h100,    0, 32'h0,      10,  5);
        add(0, 0, 0, 32'h40,        1, 32'h40,       1, 32'h200,    1, 32'h100,   1, 32'h100,    1, 32'h200,    11,  5);
        add(0, 0, 0, 32'h40,        0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h200,    0, 32'h0,      11,  6);
        add(0, 0, 1, 32'h440,       1, 32'h440,      1, 32'h300,    0, 32'h444,   0, 32'h444,    1, 32'h300,    11,  6);
        add(0, 0, 1, 32'h40,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h44,     0, 32'h0,      11,  7);
        add(0, 0, 1, 32'h442,       0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h300,    0, 32'h0,      11,  7);
        add(0, 0, 1, 32'h80,        1, 32'h80,       1, 32'h180,    0, 32'h84,    0, 32'h84,     1, 32'h180,    12,  7);
        add(0, 0, 1, 32'h80,        0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h180,    0, 32'h0,      12,  8);
        add(0, 0, 1, 32'h44,        1, 32'h44,       1, 32'h400,    0, 32'h48,    0, 32'h48,     1, 32'h400,    13,  8);
        add(0, 0, 1, 32'h44,        0, 32'h0,        0, 32'h0,      0, 32'h0,     1, 32'h400,    0, 32'h0,      13,  9);
        add(0, 1, 1, 32'h44,        1, 32'h8C,       1, 32'h500,    0, 32'h90,    1, 32'h400,    1, 32'h500,    14,  9);
        add(0, 0, 1, 32'h44,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h48,     0, 32'h0,      15, 10);
        add(0, 0, 1, 32'h8C,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h90,     0, 32'h0,      15, 10);
        add(0, 0, 1, 32'h80,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h84,     0, 32'h0,      15, 10);
        add(0, 0, 1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC, 0, 32'h0,      1, 32'h0,     0, 32'h0,      1, 32'h0,      15, 10);
        add(0, 0, 1, 32'h48,        1, 32'h48,       1, 32'h600,    0, 32'h4C,    0, 32'h4C,     1, 32'h600,    15, 11);
        add(1, 0, 1, 32'h48,        1, 32'h4C,       1, 32'h700,    0, 32'h50,    0, 32'h4C,     1, 32'h700,    15, 12);
        add(0, 0, 1, 32'h48,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h4C,     0, 32'h0,       0,  0);
        add(0, 0, 1, 32'h4C,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h50,     0, 32'h0,       0,  0);
        add(0, 0, 1, 32'h48,        0, 32'h48,       1, 32'h900,    0, 32'h0,     0, 32'h4C,     0, 32'h0,       0,  0);
        add(0, 0, 1, 32'h48,        0, 32'h0,        0, 32'h0,      0, 32'h0,     0, 32'h4C,     0, 32'h0,       0,  0);

        #2;
        check("reset.pred_taken", -1, 32'(bif.pred_taken), 32'h0);
        check("reset.pred_target", -1, bif.pred_target, 32'h44);
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #2;
            check("pred_taken", i, 32'(bif.pred_taken), 32'(vecs[i].e_ptaken));
            check("pred_target", i, bif.pred_target, vecs[i].e_ptarget);
            check("mispredict", i, 32'(bif.mispredict), 32'(vecs[i].e_mis));
            if (vecs[i].e_mis) check("recover_pc", i, bif.recover_pc, vecs[i].e_rec);
            check("hit_count", i, bif.hit_count, vecs[i].e_hits);
            check("mispredict_count", i, bif.mispredict_count, vecs[i].e_misc);
        end

        // Saturation sweep: ENTRIES=2/CNT_W=1 limit 1, ENTRIES=256/CNT_W=4 limit 15
        @(negedge clk);
        bif.RST = 1'b1; bif.upd_en = 1'b0;
        sweep_upd(1'b1);
        for (int k = 0; k < 11; k++) sweep_upd(1'b1);
        sweep_chk(100, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) sweep_upd(1'b0);
        sweep_chk(101, 1'b0, 1'b1);
        sweep_upd(1'b0);
        sweep_chk(102, 1'b0, 1'b0);
        sweep_upd(1'b1);
        sweep_chk(103, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
